// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending transaction sequencer.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        PAYOUT  = 2'd3
    } vend_state_e;

    localparam int COIN1_VAL = 1;
    localparam int COIN2_VAL = 2;

    // Credit peaks at PRICE+2 (PRICE-1 held, plus a 3-unit double-coin cycle).
    function automatic int credit_width(input int price);
        return $clog2(price + 3);
    endfunction

endpackage

// File: rtl/vend_idle_timer.sv
// Counts idle cycles while credit is held; flags expiry at IDLE_TIMEOUT-1.
module vend_idle_timer #(
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(IDLE_TIMEOUT - 1);

    logic [TW-1:0] count_q, count_d;

    assign expired = enable && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// Coin-operated vend controller: credit collection, motor handshake,
// coin-by-coin change payout, cancel and idle-timeout refunds.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE        = 3,
    parameter int IDLE_TIMEOUT = 1000,
    parameter int CREDIT_W     = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_1,
    input  logic                coin_2,
    input  logic                cancel,
    output logic                vend_req,
    input  logic                vend_ack,
    output logic                pay_req,
    output logic                pay_sel,
    input  logic                pay_ack,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                sale_done
);

    if (CREDIT_W < credit_width(PRICE)) begin : g_bad_width
        $error("vend_sequencer: CREDIT_W too narrow to hold PRICE+2");
    end
    if (PRICE < 1 || PRICE > 15) begin : g_bad_price
        $error("vend_sequencer: PRICE must be 1..15");
    end
    if (IDLE_TIMEOUT < 2 || IDLE_TIMEOUT > 65535) begin : g_bad_timeout
        $error("vend_sequencer: IDLE_TIMEOUT must be 2..65535");
    end

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                vended_q, vended_d;
    logic                vend_req_q, vend_req_d;
    logic                pay_req_q, pay_req_d;
    logic                pay_sel_q, pay_sel_d;
    logic                coin_reject_q, coin_reject_d;
    logic                busy_q, busy_d;
    logic                sale_done_q, sale_done_d;

    logic [CREDIT_W-1:0] coin_val, credit_n;
    logic                coin_any;
    logic                tmr_clear, tmr_enable, tmr_expired;

    assign coin_any = coin_1 | coin_2;
    assign coin_val = (coin_1 ? CREDIT_W'(COIN1_VAL) : '0)
                    + (coin_2 ? CREDIT_W'(COIN2_VAL) : '0);
    assign credit_n = credit_q + coin_val;

    assign tmr_enable = (state_q == COLLECT) && !coin_any;
    assign tmr_clear  = (state_q != COLLECT) || coin_any;

    vend_idle_timer #(
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) u_idle_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        change_d      = change_q;
        vended_d      = vended_q;
        coin_reject_d = 1'b0;
        sale_done_d   = 1'b0;

        unique case (state_q)
            IDLE, COLLECT: begin
                if (coin_any) begin
                    if (credit_n >= PRICE_C) begin
                        state_d  = VEND;
                        change_d = credit_n - PRICE_C;
                        credit_d = '0;
                        vended_d = 1'b0;
                    end else begin
                        state_d  = COLLECT;
                        credit_d = credit_n;
                    end
                end else if (state_q == COLLECT && (cancel || tmr_expired)) begin
                    // Refund path reuses the payout engine without a sale.
                    state_d  = PAYOUT;
                    change_d = credit_q;
                    credit_d = '0;
                    vended_d = 1'b0;
                end
            end
            VEND: begin
                coin_reject_d = coin_any;
                if (vend_ack) begin
                    if (change_q != '0) begin
                        state_d  = PAYOUT;
                        vended_d = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        sale_done_d = 1'b1;
                    end
                end
            end
            PAYOUT: begin
                coin_reject_d = coin_any;
                if (pay_ack) begin
                    change_d = change_q - ((change_q >= CREDIT_W'(2)) ? CREDIT_W'(2)
                                                                      : CREDIT_W'(1));
                    if (change_d == '0) begin
                        state_d     = IDLE;
                        sale_done_d = vended_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        vend_req_d = (state_d == VEND);
        pay_req_d  = (state_d == PAYOUT);
        pay_sel_d  = (state_d == PAYOUT) && (change_d >= CREDIT_W'(2));
        busy_d     = (state_d == VEND) || (state_d == PAYOUT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            change_q      <= '0;
            vended_q      <= 1'b0;
            vend_req_q    <= 1'b0;
            pay_req_q     <= 1'b0;
            pay_sel_q     <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
            sale_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            change_q      <= change_d;
            vended_q      <= vended_d;
            vend_req_q    <= vend_req_d;
            pay_req_q     <= pay_req_d;
            pay_sel_q     <= pay_sel_d;
            coin_reject_q <= coin_reject_d;
            busy_q        <= busy_d;
            sale_done_q   <= sale_done_d;
        end
    end

    assign vend_req    = vend_req_q;
    assign pay_req     = pay_req_q;
    assign pay_sel     = pay_sel_q;
    assign coin_reject = coin_reject_q;
    assign credit      = credit_q;
    assign busy        = busy_q;
    assign sale_done   = sale_done_q;

endmodule
